// File: rtl/wbuf_pkg.sv
// ============================================================================
//  Module      : wbuf_pkg
//  Description : Shared state encoding and address helpers for wbuf_bank_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package wbuf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EPU_OWN  = 3'd1,
        ST_H_WR     = 3'd2,
        ST_H_RD     = 3'd3,
        ST_H_RDRAIN = 3'd4
    } wbuf_state_t;

    // Word-interleaved mapping: low address bits select the bank.
    function automatic logic [31:0] bank_of(input logic [31:0] waddr, input int bank_bits);
        return waddr & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] row_of(input logic [31:0] waddr, input int bank_bits);
        return waddr >> bank_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wbuf_bank_sram.sv
// ============================================================================
//  Module      : wbuf_bank_sram
//  Description : One SRAM bank with byte enables and 1-cycle registered read.
//                Per-byte even parity is stored when WBUF_PARITY_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wbuf_bank_sram
    import wbuf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    localparam int RW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int NB    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              re,
    input  logic [NB-1:0]     we,
    input  logic [RW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
`ifdef WBUF_PARITY_EN
    ,
    output logic              perr
`endif
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            if (re) begin
                rdata <= mem[addr];
            end
        end
    end

`ifdef WBUF_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] rd_par;

    always_comb begin
        rd_par = '0;
        for (int i = 0; i < NB; i++) begin
            rd_par[i] = ^mem[addr][i*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < NB; i++) begin
                if (we[i]) begin
                    par[addr][i] <= ^wdata[i*8 +: 8];
                end
            end
            if (re) begin
                perr <= |(rd_par ^ par[addr]);
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/wbuf_bank_ctrl.sv
// ============================================================================
//  Module      : wbuf_bank_ctrl
//  Description : Host-burst / EPU arbiter onto NUM_BANKS interleaved SRAM banks.
//                Optional macro WBUF_PARITY_EN adds byte parity and parity_err_o.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wbuf_bank_ctrl
    import wbuf_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int BANK_DEPTH = 4096,
    parameter int NUM_BANKS  = 4,
    parameter int LEN_W      = 8,
    localparam int AW        = $clog2(BANK_DEPTH * NUM_BANKS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                host_req_valid,
    output logic                host_req_ready,
    input  logic                host_req_write,
    input  logic [AW+1:0]       host_req_addr,
    input  logic [LEN_W-1:0]    host_req_len,
    input  logic                host_wvalid,
    output logic                host_wready,
    input  logic [DATA_W-1:0]   host_wdata,
    input  logic [DATA_W/8-1:0] host_wstrb,
    output logic                host_rvalid,
    input  logic                host_rready,
    output logic [DATA_W-1:0]   host_rdata,
    output logic                host_rlast,
    input  logic                epu_start_i,
    input  logic                epu_finish_i,
    output logic                epu_own_o,
    input  logic                epu_cs,
    input  logic                epu_oe,
    input  logic [AW-1:0]       epu_addr,
    input  logic [DATA_W/8-1:0] epu_wen,
    input  logic [DATA_W-1:0]   epu_wdata,
    output logic [DATA_W-1:0]   epu_rdata
`ifdef WBUF_PARITY_EN
    ,
    output logic                parity_err_o
`endif
);

    localparam int NB  = DATA_W / 8;
    localparam int LG  = $clog2(NUM_BANKS);
    localparam int BW  = (LG > 0) ? LG : 1;
    localparam int RW  = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
    localparam logic [AW-1:0] ADDR_LAST = AW'(BANK_DEPTH * NUM_BANKS - 1);

    wbuf_state_t       state;
    logic [AW-1:0]     cur_addr;
    logic [AW-1:0]     next_addr;
    logic [LEN_W-1:0]  remaining;
    logic [BW-1:0]     rd_bank;
    logic              epu_rd_valid;
    logic [BW-1:0]     epu_rd_bank;

    logic              in_epu;
    logic              wr_beat;
    logic              rd_issue;
    logic              epu_read;

    logic [AW-1:0]     acc_addr;
    logic [BW-1:0]     acc_bank;
    logic [RW-1:0]     acc_row;
    logic              acc_en;
    logic              acc_re;
    logic [NB-1:0]     acc_we;
    logic [DATA_W-1:0] acc_wdata;

    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^host_req_addr[1:0];

    assign in_epu         = (state == ST_EPU_OWN);
    assign epu_own_o      = in_epu;
    assign host_req_ready = (state == ST_IDLE) && host_req_valid && !epu_start_i;
    assign host_wready    = (state == ST_H_WR);
    assign wr_beat        = host_wready && host_wvalid;
    // A new read may issue whenever the output slot is free or is draining this cycle.
    assign rd_issue       = (state == ST_H_RD) && (!host_rvalid || host_rready);
    assign epu_read       = in_epu && epu_cs && epu_oe;
    assign next_addr      = (cur_addr == ADDR_LAST) ? '0 : cur_addr + AW'(1);

    always_comb begin
        acc_addr  = cur_addr;
        acc_en    = wr_beat || rd_issue;
        acc_re    = rd_issue;
        acc_we    = wr_beat ? host_wstrb : '0;
        acc_wdata = host_wdata;
        if (in_epu) begin
            acc_addr  = epu_addr;
            acc_en    = epu_cs;
            acc_re    = epu_oe;
            acc_we    = epu_wen;
            acc_wdata = epu_wdata;
        end
    end

    assign acc_bank = BW'(bank_of(32'(acc_addr), LG));
    assign acc_row  = RW'(row_of(32'(acc_addr), LG));

`ifdef WBUF_PARITY_EN
    logic [NUM_BANKS-1:0] bank_perr;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        wbuf_bank_sram #(
            .DATA_W (DATA_W),
            .DEPTH  (BANK_DEPTH)
        ) u_sram (
            .clk    (clk),
            .en     (acc_en && (acc_bank == BW'(b))),
            .re     (acc_re),
            .we     (acc_we),
            .addr   (acc_row),
            .wdata  (acc_wdata),
            .rdata  (bank_rdata[b])
`ifdef WBUF_PARITY_EN
            ,
            .perr   (bank_perr[b])
`endif
        );
    end

    assign host_rdata = host_rvalid ? bank_rdata[rd_bank] : '0;
    assign epu_rdata  = (in_epu && epu_rd_valid) ? bank_rdata[epu_rd_bank] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cur_addr     <= '0;
            remaining    <= '0;
            host_rvalid  <= 1'b0;
            host_rlast   <= 1'b0;
            rd_bank      <= '0;
            epu_rd_valid <= 1'b0;
            epu_rd_bank  <= '0;
        end else begin
            if (host_rvalid && host_rready) begin
                host_rvalid <= 1'b0;
                host_rlast  <= 1'b0;
            end
            if (rd_issue) begin
                host_rvalid <= 1'b1;
                host_rlast  <= (remaining == '0);
                rd_bank     <= acc_bank;
            end
            if (epu_read) begin
                epu_rd_valid <= 1'b1;
                epu_rd_bank  <= acc_bank;
            end

            case (state)
                ST_IDLE: begin
                    epu_rd_valid <= 1'b0;
                    // EPU takes precedence over a simultaneous host request.
                    if (epu_start_i) begin
                        state <= ST_EPU_OWN;
                    end else if (host_req_valid) begin
                        cur_addr  <= host_req_addr[AW+1:2];
                        remaining <= host_req_len;
                        state     <= host_req_write ? ST_H_WR : ST_H_RD;
                    end
                end
                ST_EPU_OWN: begin
                    if (epu_finish_i && epu_start_i) begin
                        state <= ST_IDLE;
                    end
                end
                ST_H_WR: begin
                    if (wr_beat) begin
                        cur_addr  <= next_addr;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == '0) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_H_RD: begin
                    if (rd_issue) begin
                        cur_addr  <= next_addr;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == '0) begin
                            state <= ST_H_RDRAIN;
                        end
                    end
                end
                ST_H_RDRAIN: begin
                    if (host_rvalid && host_rready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef WBUF_PARITY_EN
    logic host_rd_chk;
    logic epu_rd_chk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_o <= 1'b0;
            host_rd_chk  <= 1'b0;
            epu_rd_chk   <= 1'b0;
        end else begin
            host_rd_chk <= rd_issue;
            epu_rd_chk  <= epu_read;
            if ((host_rd_chk && bank_perr[rd_bank]) ||
                (epu_rd_chk && bank_perr[epu_rd_bank])) begin
                parity_err_o <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wbuf_bank_ctrl.sv
// ============================================================================
//  Module      : tb_wbuf_bank_ctrl
//  Description : Self-checking bench for wbuf_bank_ctrl against a word-array model.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wbuf_bank_ctrl;

    localparam int AW    = 14;
    localparam int WORDS = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req_valid, host_req_ready, host_req_write;
    logic [15:0] host_req_addr;
    logic [7:0]  host_req_len;
    logic        host_wvalid, host_wready;
    logic [31:0] host_wdata;
    logic [3:0]  host_wstrb;
    logic        host_rvalid, host_rready, host_rlast;
    logic [31:0] host_rdata;
    logic        epu_start_i, epu_finish_i, epu_own_o, epu_cs, epu_oe;
    logic [13:0] epu_addr;
    logic [3:0]  epu_wen;
    logic [31:0] epu_wdata, epu_rdata;
`ifdef WBUF_PARITY_EN
    logic        parity_err_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] model [WORDS];
    logic [31:0] wdat  [256];
    logic [3:0]  wstb  [256];

    always #5 clk = ~clk;

    wbuf_bank_ctrl dut (
        .clk(clk), .rst(rst),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_write(host_req_write), .host_req_addr(host_req_addr),
        .host_req_len(host_req_len),
        .host_wvalid(host_wvalid), .host_wready(host_wready),
        .host_wdata(host_wdata), .host_wstrb(host_wstrb),
        .host_rvalid(host_rvalid), .host_rready(host_rready),
        .host_rdata(host_rdata), .host_rlast(host_rlast),
        .epu_start_i(epu_start_i), .epu_finish_i(epu_finish_i), .epu_own_o(epu_own_o),
        .epu_cs(epu_cs), .epu_oe(epu_oe), .epu_addr(epu_addr),
        .epu_wen(epu_wen), .epu_wdata(epu_wdata), .epu_rdata(epu_rdata)
`ifdef WBUF_PARITY_EN
        , .parity_err_o(parity_err_o)
`endif
    );

    task automatic host_req(input logic wr, input int unsigned waddr, input int unsigned len);
        logic got;
        got = 1'b0;
        @(negedge clk);
        host_req_valid = 1'b1;
        host_req_write = wr;
        host_req_addr  = {14'(waddr), 2'($urandom_range(0, 3))};
        host_req_len   = 8'(len);
        for (int c = 0; c < 50 && !got; c++) begin
            #1;
            if (host_req_ready) got = 1'b1;
            @(negedge clk);
        end
        host_req_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL req_accept: host_req_ready got 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic host_write_data(input int unsigned waddr, input int unsigned len, input int gaps);
        int k, cyc;
        int unsigned a;
        k = 0; cyc = 0;
        while (k <= int'(len) && cyc < 2000) begin
            @(negedge clk);
            host_wvalid = (gaps == 0) || ($urandom_range(0, 3) != 0);
            host_wdata  = wdat[k];
            host_wstrb  = wstb[k];
            #1;
            if (host_wvalid && host_wready) begin
                a = (waddr + k) % WORDS;
                for (int b = 0; b < 4; b++)
                    if (host_wstrb[b]) model[a][b*8 +: 8] = host_wdata[b*8 +: 8];
                k++;
            end
            cyc++;
        end
        @(negedge clk);
        host_wvalid = 1'b0;
        #1;
        checks++;
        if (cyc >= 2000 || host_wready !== 1'b0) begin
            errors++;
            $display("FAIL write_end: beats %0d of %0d, host_wready got %b expected 0", k, len + 1, host_wready);
        end
    endtask

    task automatic host_read_data(input int unsigned waddr, input int unsigned len,
                                  input int mode, input int stop_after);
        int k, cyc;
        logic pv, pr, pl, exp_last;
        logic [31:0] pd;
        int unsigned a;
        k = 0; cyc = 0; pv = 0; pr = 0; pl = 0; pd = '0;
        while (k <= int'(len) && k != stop_after && cyc < 2000) begin
            @(negedge clk);
            case (mode)
                0:       host_rready = 1'b1;
                1:       host_rready = (cyc % 3 == 0);
                default: host_rready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (pv && !pr) begin
                checks++;
                if (host_rvalid !== 1'b1 || host_rdata !== pd || host_rlast !== pl) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                             host_rvalid, host_rdata, host_rlast, pd, pl);
                end
            end
            if (host_rvalid && host_rready) begin
                a = (waddr + k) % WORDS;
                exp_last = (k == int'(len));
                checks++;
                if (host_rdata !== model[a]) begin
                    errors++;
                    $display("FAIL rdata beat %0d word %0d: got %h expected %h", k, a, host_rdata, model[a]);
                end
                checks++;
                if (host_rlast !== exp_last) begin
                    errors++;
                    $display("FAIL rlast beat %0d: got %b expected %b", k, host_rlast, exp_last);
                end
                k++;
            end
            pv = host_rvalid; pr = host_rready; pd = host_rdata; pl = host_rlast;
            cyc++;
        end
        @(posedge clk);
        #1;
        host_rready = 1'b0;
        if (cyc >= 2000) begin
            checks++; errors++;
            $display("FAIL read_timeout: beats got %0d expected %0d", k, len + 1);
        end
        if (stop_after < 0) begin
            @(negedge clk);
            #1;
            checks++;
            if (host_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL read_extra: host_rvalid got %b expected 0 after last beat", host_rvalid);
            end
        end
    endtask

    task automatic epu_access(input int unsigned a, input logic [3:0] wen,
                              input logic [31:0] d, input logic rd);
        @(negedge clk);
        epu_cs = 1'b1; epu_oe = rd; epu_addr = 14'(a); epu_wen = wen; epu_wdata = d;
        @(negedge clk);
        epu_cs = 1'b0; epu_oe = 1'b0; epu_wen = '0;
        if (rd) begin
            #1;
            checks++;
            if (epu_rdata !== model[a]) begin
                errors++;
                $display("FAIL epu_rdata word %0d: got %h expected %h", a, epu_rdata, model[a]);
            end
        end else begin
            for (int b = 0; b < 4; b++)
                if (wen[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        host_req_valid = 0; host_req_write = 0; host_req_addr = '0; host_req_len = '0;
        host_wvalid = 0; host_wdata = '0; host_wstrb = '0; host_rready = 0;
        epu_start_i = 0; epu_finish_i = 0; epu_cs = 0; epu_oe = 0;
        epu_addr = '0; epu_wen = '0; epu_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({host_req_ready, host_wready, host_rvalid, host_rlast, epu_own_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/wrdy/rvalid/rlast/own got %b expected 00000",
                     {host_req_ready, host_wready, host_rvalid, host_rlast, epu_own_o});
        end
        checks++;
        if (host_rdata !== 32'h0 || epu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rdata %h epu_rdata %h expected 0", host_rdata, epu_rdata);
        end
    endtask

    task automatic test_basic_burst;
        for (int i = 0; i < 8; i++) begin wdat[i] = 32'h100 + 32'(i); wstb[i] = 4'hF; end
        host_req(1'b1, 0, 7);
        host_write_data(0, 7, 0);
        host_req(1'b0, 0, 7);
        host_read_data(0, 7, 0, -1);
    endtask

    task automatic test_strobe;
        wdat[0] = 32'hAABBCCDD; wstb[0] = 4'hF;
        host_req(1'b1, 5, 0);
        host_write_data(5, 0, 0);
        wdat[0] = 32'h00001100; wstb[0] = 4'b0010;
        host_req(1'b1, 5, 0);
        host_write_data(5, 0, 0);
        host_req(1'b0, 5, 0);
        host_read_data(5, 0, 0, -1);
    endtask

    task automatic test_backpressure;
        host_req(1'b0, 0, 3);
        host_read_data(0, 3, 1, -1);
    endtask

    task automatic test_fill_and_random;
        int unsigned len, a;
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
            host_req(1'b1, blk * 256, 255);
            host_write_data(blk * 256, 255, 0);
        end
        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(0, 15);
            a   = $urandom_range(0, 1023 - len);
            for (int i = 0; i < 16; i++) begin
                wdat[i] = $urandom;
                wstb[i] = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
            host_req(1'b1, a, len);
            host_write_data(a, len, 1);
            a = $urandom_range(0, 1000);
            len = $urandom_range(0, 15);
            host_req(1'b0, a, len);
            host_read_data(a, len, 2, -1);
        end
    endtask

    task automatic test_epu_priority;
        int unsigned a;
        @(negedge clk);
        epu_start_i = 1'b1;
        host_req_valid = 1'b1; host_req_write = 1'b0;
        host_req_addr = {14'd100, 2'b00}; host_req_len = 8'd3;
        #1;
        checks++;
        if (host_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_ready: host_req_ready got %b expected 0", host_req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (epu_own_o !== 1'b1 || host_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_own: own %b ready %b expected own 1 ready 0", epu_own_o, host_req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            a = $urandom_range(0, 1023);
            epu_access(a, 4'($urandom_range(0, 15)), $urandom, 1'b0);
            epu_access(a, 4'h0, 32'h0, 1'b1);
        end
        epu_access(100, 4'hF, 32'hC0FFEE00, 1'b0);
        @(negedge clk);
        epu_finish_i = 1'b1;
        @(negedge clk);
        epu_finish_i = 1'b0; epu_start_i = 1'b0;
        #1;
        checks++;
        if (epu_own_o !== 1'b0 || host_req_ready !== 1'b1 || epu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL prio_release: own %b ready %b epu_rdata %h expected 0 1 0",
                     epu_own_o, host_req_ready, epu_rdata);
        end
        @(negedge clk);
        host_req_valid = 1'b0;
        host_read_data(100, 3, 0, -1);
    endtask

    task automatic test_defer;
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        host_req(1'b1, 200, 3);
        epu_start_i = 1'b1;
        host_write_data(200, 3, 0);
        checks++;
        if (epu_own_o !== 1'b0) begin
            errors++;
            $display("FAIL defer_own: epu_own_o got %b expected 0 at burst end", epu_own_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (epu_own_o !== 1'b1) begin
            errors++;
            $display("FAIL defer_take: epu_own_o got %b expected 1", epu_own_o);
        end
        epu_finish_i = 1'b1;
        @(negedge clk);
        epu_finish_i = 1'b0; epu_start_i = 1'b0;
        host_req(1'b0, 200, 3);
        host_read_data(200, 3, 2, -1);
    endtask

    task automatic test_wrap;
        wdat[0] = $urandom; wdat[1] = $urandom; wstb[0] = 4'hF; wstb[1] = 4'hF;
        host_req(1'b1, WORDS - 1, 1);
        host_write_data(WORDS - 1, 1, 0);
        host_req(1'b0, 0, 0);
        host_read_data(0, 0, 0, -1);
        host_req(1'b0, WORDS - 1, 1);
        host_read_data(WORDS - 1, 1, 0, -1);
    endtask

    task automatic test_reset_mid_burst;
        host_req(1'b0, 16, 3);
        host_read_data(16, 3, 0, 2);
        rst = 1'b1;
        #1;
        checks++;
        if (host_rvalid !== 1'b0 || host_rdata !== 32'h0 || host_rlast !== 1'b0 || host_wready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rvalid %b rdata %h rlast %b wready %b expected all 0",
                     host_rvalid, host_rdata, host_rlast, host_wready);
        end
        @(negedge clk);
        rst = 1'b0;
        host_req(1'b0, 16, 3);
        host_read_data(16, 3, 2, -1);
    endtask

    initial begin
        test_reset();
        test_basic_burst();
        test_strobe();
        test_backpressure();
        test_fill_and_random();
        test_epu_priority();
        test_defer();
        test_wrap();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
